// File: rtl/dekatron_step_sequencer_if.sv
// Command handshake bundle for the dekatron step sequencer.
// The sequencer takes the slave side; the command source takes the master side.
interface dekatron_step_sequencer_if #(
   parameter int D_NUM = 6,
   parameter int CNT_W = 8
);
   logic                 CmdValid;
   logic                 CmdReady;
   logic [1:0]           CmdOp;
   logic [CNT_W-1:0]     CmdSteps;
   logic [D_NUM*4-1:0]   CmdData;

   modport master (
      output CmdValid, CmdOp, CmdSteps, CmdData,
      input  CmdReady
   );

   modport slave (
      input  CmdValid, CmdOp, CmdSteps, CmdData,
      output CmdReady
   );
endinterface

// File: rtl/dekatron_step_sequencer.sv
// Breaks inc/dec/load/clear commands into single request/acknowledge
// transactions towards a BCD dekatron counter.
module dekatron_step_sequencer #(
   parameter int D_NUM   = 6,
   parameter int CNT_W   = 8,
   parameter int ACK_TMO = 15
) (
   input  logic                 Clk,
   input  logic                 Rst_n,
   dekatron_step_sequencer_if.slave cmd,
   output logic                 Request,
   output logic                 Dec,
   output logic                 Set,
   output logic [D_NUM*4-1:0]   In,
   input  logic                 Ready,
   output logic                 Busy,
   output logic                 Done,
   output logic                 Error,
   output logic [CNT_W-1:0]     StepsLeft
);

   localparam int TMO_W = $clog2(ACK_TMO + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_ACK,
      S_WAIT_DONE,
      S_FINISH
   } state_e;

   state_e               state_q, state_d;
   logic                 multi_q, multi_d;
   logic [CNT_W-1:0]     steps_q, steps_d;
   logic [D_NUM*4-1:0]   in_q, in_d;
   logic                 dec_q, dec_d;
   logic                 set_q, set_d;
   logic                 err_q, err_d;
   logic [TMO_W-1:0]     tmo_q, tmo_d;
   logic                 accept;

   assign cmd.CmdReady = Rst_n && (state_q == S_IDLE);
   assign accept       = cmd.CmdValid && cmd.CmdReady;

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q <= S_IDLE;
         multi_q <= 1'b0;
         steps_q <= '0;
         in_q    <= '0;
         dec_q   <= 1'b0;
         set_q   <= 1'b0;
         err_q   <= 1'b0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         multi_q <= multi_d;
         steps_q <= steps_d;
         in_q    <= in_d;
         dec_q   <= dec_d;
         set_q   <= set_d;
         err_q   <= err_d;
         tmo_q   <= tmo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      multi_d = multi_q;
      steps_d = steps_q;
      in_d    = in_q;
      dec_d   = dec_q;
      set_d   = set_q;
      err_d   = err_q;
      tmo_d   = tmo_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               err_d = 1'b0;
               tmo_d = '0;
               multi_d = !cmd.CmdOp[1];
               if (cmd.CmdOp[1]) begin
                  steps_d = CNT_W'(1);
                  set_d   = 1'b1;
                  dec_d   = 1'b0;
                  in_d    = cmd.CmdOp[0] ? '0 : cmd.CmdData;
                  state_d = S_ISSUE;
               end else begin
                  steps_d = cmd.CmdSteps;
                  set_d   = 1'b0;
                  dec_d   = cmd.CmdOp[0];
                  in_d    = '0;
                  state_d = (cmd.CmdSteps == '0) ? S_FINISH : S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            tmo_d = '0;
            if (Ready) state_d = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            if (!Ready) begin
               state_d = S_WAIT_DONE;
            end else if (tmo_q == TMO_W'(ACK_TMO - 1)) begin
               // counter never went busy: abandon the rest of the command
               err_d   = 1'b1;
               state_d = S_FINISH;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         S_WAIT_DONE: begin
            if (Ready) begin
               if (steps_q != '0) steps_d = steps_q - 1'b1;
               if (multi_q && steps_q > CNT_W'(1)) state_d = S_ISSUE;
               else state_d = S_FINISH;
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   assign Request   = (state_q == S_ISSUE) && Ready;
   assign Dec       = dec_q;
   assign Set       = set_q;
   assign In        = in_q;
   assign Busy      = (state_q != S_IDLE);
   assign Done      = (state_q == S_FINISH);
   assign Error     = err_q;
   assign StepsLeft = steps_q;

endmodule

// File: tb/tb_dekatron_step_sequencer.sv
// Directed bench: sequencer driving a 6-digit BCD dekatron counter model.
module tb_dekatron_step_sequencer;

   logic        Clk = 1'b0;
   logic        Rst_n;
   logic        Request, Dec, Set, Ready, Busy, Done, Error;
   logic [23:0] In;
   logic [7:0]  StepsLeft;

   int n_chk = 0;
   int n_err = 0;

   dekatron_step_sequencer_if #(.D_NUM(6), .CNT_W(8)) cmd_if ();

   dekatron_step_sequencer #(.D_NUM(6), .CNT_W(8), .ACK_TMO(15)) dut (
      .Clk       (Clk),
      .Rst_n     (Rst_n),
      .cmd       (cmd_if.slave),
      .Request   (Request),
      .Dec       (Dec),
      .Set       (Set),
      .In        (In),
      .Ready     (Ready),
      .Busy      (Busy),
      .Done      (Done),
      .Error     (Error),
      .StepsLeft (StepsLeft)
   );

   always #5 Clk = ~Clk;

   function automatic logic [23:0] bcd_inc(input logic [23:0] v);
      logic [23:0] r;
      logic c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (c) begin
            if (r[i*4 +: 4] == 4'd9) r[i*4 +: 4] = 4'd0;
            else begin r[i*4 +: 4] = r[i*4 +: 4] + 4'd1; c = 1'b0; end
         end
      end
      return r;
   endfunction

   function automatic logic [23:0] bcd_dec(input logic [23:0] v);
      logic [23:0] r;
      logic c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (c) begin
            if (r[i*4 +: 4] == 4'd0) r[i*4 +: 4] = 4'd9;
            else begin r[i*4 +: 4] = r[i*4 +: 4] - 4'd1; c = 1'b0; end
         end
      end
      return r;
   endfunction

   // counter model: busy for 3 cycles after each accepted request
   logic [23:0] cnt = '0;
   int          bsy = 0;
   logic        noack = 1'b0;
   logic        force_lo = 1'b0;

   always @(posedge Clk) begin
      if (Request && !noack) begin
         if (Set) cnt <= In;
         else if (Dec) cnt <= bcd_dec(cnt);
         else cnt <= bcd_inc(cnt);
         bsy <= 3;
      end else if (bsy != 0) begin
         bsy <= bsy - 1;
      end
   end

   assign Ready = !force_lo && (bsy == 0);

   logic        clr = 1'b0;
   int          req_cnt = 0;
   int          done_cnt = 0;
   logic        dec_or = 1'b0;
   logic        dec_and = 1'b1;
   logic        set_or = 1'b0;
   logic [23:0] last_in = '0;

   always @(posedge Clk) begin
      if (clr) begin
         req_cnt  <= 0;
         done_cnt <= 0;
         dec_or   <= 1'b0;
         dec_and  <= 1'b1;
         set_or   <= 1'b0;
         last_in  <= '0;
      end else begin
         if (Request) begin
            req_cnt <= req_cnt + 1;
            dec_or  <= dec_or | Dec;
            dec_and <= dec_and & Dec;
            set_or  <= set_or | Set;
            last_in <= In;
         end
         if (Done) done_cnt <= done_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic clear_mon();
      clr = 1'b1;
      @(negedge Clk);
      clr = 1'b0;
   endtask

   task automatic send(input logic [1:0] op, input logic [7:0] st,
                       input logic [23:0] d);
      check("cmd_ready", 64'(cmd_if.CmdReady), 64'd1);
      cmd_if.CmdValid = 1'b1;
      cmd_if.CmdOp    = op;
      cmd_if.CmdSteps = st;
      cmd_if.CmdData  = d;
      @(negedge Clk);
      cmd_if.CmdValid = 1'b0;
      cmd_if.CmdOp    = 2'b00;
      cmd_if.CmdSteps = 8'hff;
      cmd_if.CmdData  = 24'h987654;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!Done && n < 300) begin
         @(negedge Clk);
         n++;
      end
      check("done_seen", 64'(Done), 64'd1);
   endtask

   int n;
   int r;

   initial begin
      Rst_n = 1'b0;
      cmd_if.CmdValid = 1'b0;
      cmd_if.CmdOp    = 2'b00;
      cmd_if.CmdSteps = '0;
      cmd_if.CmdData  = '0;
      repeat (3) @(negedge Clk);
      check("rst_req",   64'(Request), 64'd0);
      check("rst_busy",  64'(Busy), 64'd0);
      check("rst_done",  64'(Done), 64'd0);
      check("rst_err",   64'(Error), 64'd0);
      check("rst_steps", 64'(StepsLeft), 64'd0);
      check("rst_rdy",   64'(cmd_if.CmdReady), 64'd0);
      check("rst_in",    64'({Dec, Set, In}), 64'd0);
      Rst_n = 1'b1;
      @(negedge Clk);
      check("rdy_after_rst", 64'(cmd_if.CmdReady), 64'd1);

      // increment by 5
      clear_mon();
      send(2'b00, 8'd5, 24'h0);
      check("inc5_steps0", 64'(StepsLeft), 64'd5);
      check("inc5_busy", 64'(Busy), 64'd1);
      wait_done(n);
      @(negedge Clk);
      check("inc5_reqs", 64'(req_cnt), 64'd5);
      check("inc5_dec", 64'(dec_or), 64'd0);
      check("inc5_done", 64'(done_cnt), 64'd1);
      check("inc5_out", 64'(cnt), 64'h000005);
      check("inc5_left", 64'(StepsLeft), 64'd0);
      check("inc5_idle", 64'(Busy), 64'd0);

      // load 123456 then decrement 3
      clear_mon();
      send(2'b10, 8'd0, 24'h123456);
      check("ld_steps0", 64'(StepsLeft), 64'd1);
      wait_done(n);
      @(negedge Clk);
      check("ld_reqs", 64'(req_cnt), 64'd1);
      check("ld_set", 64'(set_or), 64'd1);
      check("ld_in", 64'(last_in), 64'h123456);
      check("ld_out", 64'(cnt), 64'h123456);
      clear_mon();
      send(2'b01, 8'd3, 24'h0);
      wait_done(n);
      @(negedge Clk);
      check("dec3_reqs", 64'(req_cnt), 64'd3);
      check("dec3_dec", 64'(dec_and), 64'd1);
      check("dec3_set", 64'(set_or), 64'd0);
      check("dec3_out", 64'(cnt), 64'h123453);

      // zero-step increment
      clear_mon();
      send(2'b00, 8'd0, 24'h0);
      check("z_done", 64'(Done), 64'd1);
      check("z_busy", 64'(Busy), 64'd1);
      check("z_req", 64'(Request), 64'd0);
      @(negedge Clk);
      check("z_done_end", 64'(Done), 64'd0);
      check("z_busy_end", 64'(Busy), 64'd0);
      check("z_reqs", 64'(req_cnt), 64'd0);
      check("z_done_cnt", 64'(done_cnt), 64'd1);

      // counter never acknowledges
      noack = 1'b1;
      clear_mon();
      send(2'b00, 8'd4, 24'h0);
      wait_done(n);
      check("tmo_cycles", 64'(n), 64'd16);
      check("tmo_err", 64'(Error), 64'd1);
      check("tmo_steps", 64'(StepsLeft), 64'd4);
      @(negedge Clk);
      noack = 1'b0;
      check("tmo_reqs", 64'(req_cnt), 64'd1);
      check("tmo_done_cnt", 64'(done_cnt), 64'd1);
      check("tmo_sticky", 64'(Error), 64'd1);
      check("tmo_idle", 64'(Busy), 64'd0);

      // Ready low at acceptance
      clear_mon();
      force_lo = 1'b1;
      send(2'b10, 8'd0, 24'h000042);
      check("hold_err_clr", 64'(Error), 64'd0);
      repeat (5) @(negedge Clk);
      check("hold_noreq", 64'(req_cnt), 64'd0);
      check("hold_busy", 64'(Busy), 64'd1);
      check("hold_stable", 64'({Set, In}), 64'h1000042);
      force_lo = 1'b0;
      wait_done(n);
      @(negedge Clk);
      check("hold_reqs", 64'(req_cnt), 64'd1);
      check("hold_out", 64'(cnt), 64'h000042);

      // Ready toggling in idle
      clear_mon();
      repeat (6) begin
         force_lo = ~force_lo;
         @(negedge Clk);
      end
      force_lo = 1'b0;
      check("idle_toggle", 64'(req_cnt), 64'd0);

      // clear to zero
      clear_mon();
      send(2'b11, 8'd7, 24'h999999);
      wait_done(n);
      @(negedge Clk);
      check("clr_reqs", 64'(req_cnt), 64'd1);
      check("clr_in", 64'(last_in), 64'h0);
      check("clr_out", 64'(cnt), 64'h0);

      // reset during WAIT_DONE of a 10-step increment
      clear_mon();
      send(2'b00, 8'd10, 24'h0);
      n = 0;
      while (!(req_cnt == 2 && !Ready) && n < 200) begin
         @(negedge Clk);
         n++;
      end
      check("mid_reached", 64'(req_cnt), 64'd2);
      @(negedge Clk);
      Rst_n = 1'b0;
      @(negedge Clk);
      check("mid_busy", 64'(Busy), 64'd0);
      check("mid_req", 64'(Request), 64'd0);
      check("mid_steps", 64'(StepsLeft), 64'd0);
      check("mid_rdy", 64'(cmd_if.CmdReady), 64'd0);
      check("mid_outs", 64'({Dec, Set, In, Done, Error}), 64'd0);
      Rst_n = 1'b1;
      @(negedge Clk);
      check("mid_rdy_rel", 64'(cmd_if.CmdReady), 64'd1);
      r = req_cnt;
      repeat (20) @(negedge Clk);
      check("mid_noreq", 64'(req_cnt), 64'd2);
      check("mid_noreq_r", 64'(req_cnt - r), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/dekatron_step_sequencer.md
DEKATRON_STEP_SEQUENCER -- requirements
Module: dekatron_step_sequencer

Interface
REQ-001 Parameter D_NUM, default 6, number of BCD dekatron digits driven on In.
REQ-002 Parameter CNT_W, default 8, width of the step-count field.
REQ-003 Parameter ACK_TMO, default 15, maximum Clk cycles to wait for counter acknowledge.
REQ-004 Clk  input  1  block clock; all state changes on rising edge.
REQ-005 Rst_n  input  1  reset, synchronous, active-low.
REQ-006 CmdValid  input  1  command offered.
REQ-007 CmdReady  output  1  sequencer can accept a command.
REQ-008 CmdOp  input  2  00 increment, 01 decrement, 10 load CmdData, 11 clear to zero.
REQ-009 CmdSteps  input  CNT_W  number of unit steps for increment/decrement.
REQ-010 CmdData  input  D_NUM*4  BCD load value for op 10.
REQ-011 Request  output  1  one-cycle step/load request to the counter.
REQ-012 Dec  output  1  counter direction, 1 = decrement.
REQ-013 Set  output  1  counter load strobe qualifier.
REQ-014 In  output  D_NUM*4  counter load value.
REQ-015 Ready  input  1  counter idle/complete status.
REQ-016 Busy  output  1  a command is in progress.
REQ-017 Done  output  1  one-cycle pulse when a command finishes.
REQ-018 Error  output  1  sticky acknowledge-timeout flag.
REQ-019 StepsLeft  output  CNT_W  remaining steps of the current command.

Function
REQ-020 CmdReady SHALL equal 1 only in state IDLE; a command is accepted on a rising edge with CmdValid=1 and CmdReady=1.
REQ-021 On acceptance, CmdOp, CmdSteps and CmdData SHALL be registered; later input changes have no effect until the next acceptance.
REQ-022 States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, FINISH.
REQ-023 IDLE -> ISSUE on acceptance, except increment/decrement with CmdSteps=0 -> FINISH directly with no Request.
REQ-024 In ISSUE, Request SHALL assert for exactly one cycle, only on a cycle where Ready=1; otherwise stay in ISSUE with Request=0.
REQ-025 ISSUE -> WAIT_ACK on the cycle Request is driven.
REQ-026 WAIT_ACK -> WAIT_DONE when Ready=0 is sampled.
REQ-027 WAIT_ACK -> FINISH with Error set if Ready stays 1 for ACK_TMO consecutive cycles after Request; remaining steps are abandoned.
REQ-028 WAIT_DONE on Ready=1: decrement StepsLeft; if result nonzero and op is inc/dec -> ISSUE, else -> FINISH.
REQ-029 Load and clear SHALL issue exactly one transaction with Set=1; In=CmdData for load, In=0 for clear.
REQ-030 Increment/decrement SHALL issue CmdSteps transactions with Set=0, Dec=CmdOp[0], In=0.
REQ-031 Dec, Set and In SHALL be stable from entry to ISSUE until exit from WAIT_DONE.
REQ-032 StepsLeft SHALL load CmdSteps (1 for load/clear) on acceptance and never wrap below 0.
REQ-033 FINISH SHALL last one cycle, assert Done=1, then return to IDLE; Busy=1 in all states except IDLE.
REQ-034 Error SHALL clear only on reset or on acceptance of the next command.
REQ-035 Ready toggling while in IDLE SHALL produce no Request.

Reset
REQ-036 While Rst_n=0 at a rising edge: state IDLE, Request=0, Dec=0, Set=0, In=0, Busy=0, Done=0, Error=0, StepsLeft=0, CmdReady=0 for that cycle and 1 after release.
REQ-037 Reset mid-command SHALL abandon the command; Request SHALL not assert again until a new command is accepted.

Verification
REQ-038 Increment CmdSteps=5 with counter model (Ready low 3 cycles per request) -> exactly 5 Request pulses, Dec=0, Done once, counter Out=000005.
REQ-039 Load CmdData=0x123456 then decrement CmdSteps=3 -> one Set=1 request with In=0x123456, then 3 Dec=1 requests, Out=123453.
REQ-040 Increment CmdSteps=0 -> no Request, Done pulses one cycle after acceptance, Busy high one cycle.
REQ-041 Model never drops Ready after Request -> Error=1 after ACK_TMO=15 cycles, Done pulses, StepsLeft frozen at value at timeout.
REQ-042 Ready held 0 when command accepted -> Request withheld until Ready=1, then single pulse.
REQ-043 Rst_n=0 during WAIT_DONE of a 10-step increment -> next edge all outputs at reset values, no further Request.
